// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension unit, one shift-add or restoring-divide step per cycle.
// Divide-by-zero and signed overflow may optionally bypass iteration.
module muldiv_unit #(
    parameter int XLEN         = 32,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            start,
    input  logic            flush,
    output logic            IsMulDiv,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_m;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg, r_sa;
    logic              w_div, w_sa, w_sb, w_zero, w_ovf, w_special, w_accept, w_last, w_ge;
    logic [XLEN-1:0]   w_ma, w_mb, w_special_res, w_dr, w_quo, w_rem, w_final;
    logic [XLEN:0]     w_sum, w_sh;
    logic [2*XLEN-1:0] w_step, w_prod;

    assign IsMulDiv = ALUOp == 2'b10 && Funct7 == 7'b0000001;
    assign w_div    = Funct3[2];
    assign w_sa     = SrcA[XLEN-1] && (Funct3 == 3'b001 || Funct3 == 3'b010 || Funct3 == 3'b100 || Funct3 == 3'b110);
    assign w_sb     = SrcB[XLEN-1] && (Funct3 == 3'b001 || Funct3 == 3'b100 || Funct3 == 3'b110);
    assign w_ma     = w_sa ? -SrcA : SrcA;
    assign w_mb     = w_sb ? -SrcB : SrcB;
    assign w_zero   = SrcB == '0;
    assign w_ovf    = !Funct3[0] && SrcA == {1'b1, {(XLEN-1){1'b0}}} && SrcB == '1;
    assign w_special     = FAST_SPECIAL && w_div && (w_zero || w_ovf);
    assign w_special_res = w_zero ? (Funct3[1] ? SrcA : '1) : (Funct3[1] ? '0 : SrcA);
    assign w_accept = r_state == IDLE && start && IsMulDiv && !flush;
    assign w_last   = r_state == CALC && r_cnt == '0;

    // Multiply keeps {partial, multiplier} and shifts right; divide keeps {remainder, quotient} and shifts left.
    assign w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge   = w_sh >= {1'b0, r_m};
    assign w_dr   = w_ge ? XLEN'(w_sh - {1'b0, r_m}) : w_sh[XLEN-1:0];
    assign w_step = r_op[2] ? {w_dr, r_acc[XLEN-2:0], w_ge} : {w_sum, r_acc[XLEN-1:1]};

    assign w_prod  = r_neg ? -w_step : w_step;
    assign w_quo   = r_neg ? -w_step[XLEN-1:0] : w_step[XLEN-1:0];
    assign w_rem   = r_sa ? -w_step[2*XLEN-1:XLEN] : w_step[2*XLEN-1:XLEN];
    assign w_final = !r_op[2] ? (r_op[1:0] == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN])
                              : (r_op[1] ? w_rem : w_quo);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (flush)
            w_next = IDLE;
        else if (w_accept)
            w_next = w_special ? DONE : CALC;
        else if (w_last)
            w_next = DONE;
        else if (r_state == DONE)
            w_next = IDLE;
    end

    assign busy = r_state != IDLE;
    assign done = r_state == DONE && !flush;

    // A zero divisor never negates the quotient so it stays all-ones regardless of dividend sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_op   <= '0;
            r_m    <= '0;
            r_acc  <= '0;
            r_neg  <= 1'b0;
            r_sa   <= 1'b0;
            Result <= '0;
        end else if (w_accept) begin
            r_cnt <= CW'(XLEN-1);
            r_op  <= Funct3;
            r_m   <= w_div ? w_mb : w_ma;
            r_acc <= {{XLEN{1'b0}}, (w_div ? w_ma : w_mb)};
            r_neg <= (w_sa ^ w_sb) && !(w_div && w_zero);
            r_sa  <= w_sa;
            if (w_special)
                Result <= w_special_res;
        end else if (r_state == CALC && !flush) begin
            r_cnt <= r_cnt - 1'b1;
            r_acc <= w_step;
            if (w_last)
                Result <= w_final;
        end
    end
endmodule
